// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble insertion and D-cache miss freeze.
// Optional stall-cycle counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
  parameter int unsigned FILL_CYCLES = 1
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memRead_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             dmem_access_i,
  input  logic             dmem_hit_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic             memwb_stall_o,
`ifdef PIPE_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
`endif
  output logic             busy_o
);

  localparam int unsigned FillW = 4;
  localparam logic [FillW-1:0] FillLoad = FillW'(FILL_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FillW-1:0] fill_cnt_q, fill_cnt_d;
  logic             mem_req_q, mem_req_d;

  logic lu;
  logic miss;
  logic freeze;

  assign lu = idex_memRead_i && (idex_rd_i != 5'd0) &&
              ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));
  assign miss = dmem_access_i && !dmem_hit_i;

  // A miss seen in IDLE freezes the pipe in the same cycle, before the FSM leaves IDLE.
  assign freeze = (state_q != StIdle) || miss;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    mem_req_d  = mem_req_q;
    unique case (state_q)
      StIdle: begin
        if (miss) begin
          state_d   = StReq;
          mem_req_d = 1'b1;
        end
      end
      StReq: begin
        if (mem_ack_i) begin
          state_d    = StFill;
          mem_req_d  = 1'b0;
          fill_cnt_d = FillLoad;
        end
      end
      StFill: begin
        if (fill_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          fill_cnt_d = fill_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        mem_req_d  = 1'b0;
        fill_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      mem_req_q  <= mem_req_d;
    end
  end

  // Stall outputs are gated by reset so a live miss input cannot leak through while in reset.
  always_comb begin
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_stall_o = 1'b0;
    memwb_stall_o = 1'b0;
    if (rst_i) begin
      if (freeze) begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_stall_o  = 1'b1;
        exmem_stall_o = 1'b1;
        memwb_stall_o = 1'b1;
      end else if (lu) begin
        pc_stall_o   = 1'b1;
        ifid_stall_o = 1'b1;
        idex_flush_o = 1'b1;
      end
    end
  end

  assign mem_req_o = mem_req_q;
  assign busy_o    = (state_q != StIdle);

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
